// File: rtl/sprite_anim_show_if.sv
// ROM read bus for sprite_anim_show.
//   master (renderer): drives rom_addr / rom_frame, receives rom_data.
//   slave  (ROM)     : receives rom_addr / rom_frame, drives rom_data.
//   rom_addr  ADDR_W   registered pixel address inside one frame
//   rom_frame FRAME_W  registered animation frame select
//   rom_data  6        bit 5 opaque, bits 4:0 palette index
interface sprite_anim_show_if #(
    parameter int ADDR_W  = 13,
    parameter int FRAME_W = 4
);
    logic [ADDR_W-1:0]  rom_addr;
    logic [FRAME_W-1:0] rom_frame;
    logic [5:0]         rom_data;

    modport master (output rom_addr, output rom_frame, input rom_data);
    modport slave  (input rom_addr, input rom_frame, output rom_data);
endinterface

// File: rtl/sprite_anim_show.sv
// Animated sprite renderer for the VGA game layer.
// Maps the scan pixel to an address in an external multi-frame index ROM,
// steps animation frames on frame_tick, resolves the index through a 32x24
// writable palette and emits an RGB pixel with a valid flag, L = 2+ROM_LAT.
// Ports:
//   clk, rst                        pixel clock, synchronous active-high reset
//   current_pixel_x/y               scan position
//   sprite_valid, sprite_x/y        sprite enable and top-left corner
//   mirror                          horizontal flip
//   frame_tick, anim_restart        video-frame pulse, sequencer restart
//   anim_mode, static_frame         sequencer mode and static frame (sampled on restart)
//   rom (master)                    rom_addr / rom_frame out, rom_data in
//   pal_we, pal_addr, pal_data      palette write port
//   sprite_pixel, sprite_pixel_valid  registered RGB and opaque-hit flag
//   anim_frame, anim_done           current frame, one-shot finished
module sprite_anim_show #(
    parameter int SPR_W      = 88,
    parameter int SPR_H      = 84,
    parameter int NUM_FRAMES = 13,
    parameter int FRAME_W    = 4,
    parameter int ADDR_W     = 13,
    parameter int ROM_LAT    = 1,
    parameter int HOLD_TICKS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [9:0]           current_pixel_x,
    input  logic [9:0]           current_pixel_y,
    input  logic                 sprite_valid,
    input  logic [9:0]           sprite_x,
    input  logic [9:0]           sprite_y,
    input  logic                 mirror,
    input  logic                 frame_tick,
    input  logic                 anim_restart,
    input  logic [1:0]           anim_mode,
    input  logic [FRAME_W-1:0]   static_frame,
    sprite_anim_show_if.master   rom,
    input  logic                 pal_we,
    input  logic [4:0]           pal_addr,
    input  logic [23:0]          pal_data,
    output logic [23:0]          sprite_pixel,
    output logic                 sprite_pixel_valid,
    output logic [FRAME_W-1:0]   anim_frame,
    output logic                 anim_done
);
    localparam int HOLD_W = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
    localparam logic [FRAME_W-1:0] LAST_FRAME = FRAME_W'(NUM_FRAMES - 1);
    localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_TICKS - 1);

    typedef enum logic [2:0] {
        S_STATIC, S_LOOP, S_ONESHOT, S_DONE, S_PP_UP, S_PP_DOWN
    } state_t;

    state_t               state_q, state_d;
    logic [FRAME_W-1:0]   frame_q, frame_d;
    logic [HOLD_W-1:0]    hold_q, hold_d;
    logic                 advance;

    logic [ADDR_W-1:0]    rom_addr_q, rom_addr_d;
    logic [FRAME_W-1:0]   rom_frame_q, rom_frame_d;
    logic                 hit_q, hit_d;
    logic [ROM_LAT-1:0]   hit_dly_q, hit_dly_d;
    logic [23:0]          pix_q, pix_d;
    logic                 pix_valid_q, pix_valid_d;
    logic [23:0]          pal_q [32];
    logic [23:0]          pal_d [32];

    logic [10:0]          px, py, sx, sy, x_hi, y_hi, row, col_raw, col;
    logic                 hit, opaque;
    logic [ADDR_W-1:0]    addr;

    // Hit test and address, all at 11 bits so sprite_x+SPR_W-1 cannot wrap.
    always_comb begin
        px      = {1'b0, current_pixel_x};
        py      = {1'b0, current_pixel_y};
        sx      = {1'b0, sprite_x};
        sy      = {1'b0, sprite_y};
        x_hi    = sx + 11'(SPR_W - 1);
        y_hi    = sy + 11'(SPR_H - 1);
        hit     = sprite_valid && (px >= sx) && (px <= x_hi) && (py >= sy) && (py <= y_hi);
        // ROM row 0 is the bottom line of the sprite.
        row     = y_hi - py;
        col_raw = px - sx;
        col     = mirror ? 11'(SPR_W - 1) - col_raw : col_raw;
        addr    = hit ? ADDR_W'(row) * ADDR_W'(SPR_W) + ADDR_W'(col) : '0;
    end

    // Animation sequencer; restart wins over a simultaneous tick.
    always_comb begin
        state_d = state_q;
        frame_d = frame_q;
        hold_d  = hold_q;
        advance = 1'b0;
        if (anim_restart) begin
            hold_d  = '0;
            frame_d = '0;
            unique case (anim_mode)
                2'b00: begin
                    state_d = S_STATIC;
                    frame_d = static_frame;
                end
                2'b01:   state_d = S_LOOP;
                2'b10:   state_d = S_ONESHOT;
                default: state_d = S_PP_UP;
            endcase
        end else if (frame_tick && state_q != S_STATIC) begin
            if (hold_q == HOLD_LAST) begin
                hold_d  = '0;
                advance = 1'b1;
            end else begin
                hold_d = hold_q + 1'b1;
            end
        end
        if (advance) begin
            case (state_q)
                S_LOOP: frame_d = (frame_q == LAST_FRAME) ? '0 : frame_q + 1'b1;
                S_ONESHOT: begin
                    if (frame_q == LAST_FRAME) state_d = S_DONE;
                    else                       frame_d = frame_q + 1'b1;
                end
                S_PP_UP: begin
                    // A single-frame ping-pong never moves.
                    if (NUM_FRAMES > 1) begin
                        frame_d = frame_q + 1'b1;
                        if (frame_q + 1'b1 == LAST_FRAME) state_d = S_PP_DOWN;
                    end
                end
                S_PP_DOWN: begin
                    frame_d = frame_q - 1'b1;
                    if (frame_q == FRAME_W'(1)) state_d = S_PP_UP;
                end
                default: ;
            endcase
        end
    end

    // Pixel pipeline: stage 1 registers, hit delayed to line up with rom_data.
    always_comb begin
        rom_addr_d  = addr;
        rom_frame_d = frame_q;
        hit_d       = hit;
        hit_dly_d   = hit_dly_q << 1;
        hit_dly_d[0] = hit_q;
        opaque      = hit_dly_q[ROM_LAT-1] && rom.rom_data[5];
        // Palette read sees the pre-write value when addressed in the write cycle.
        pix_d       = opaque ? pal_q[rom.rom_data[4:0]] : '0;
        pix_valid_d = opaque;
        pal_d       = pal_q;
        if (pal_we) pal_d[pal_addr] = pal_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_STATIC;
            frame_q     <= '0;
            hold_q      <= '0;
            rom_addr_q  <= '0;
            rom_frame_q <= '0;
            hit_q       <= 1'b0;
            hit_dly_q   <= '0;
            pix_q       <= '0;
            pix_valid_q <= 1'b0;
            pal_q       <= '{default: '0};
        end else begin
            state_q     <= state_d;
            frame_q     <= frame_d;
            hold_q      <= hold_d;
            rom_addr_q  <= rom_addr_d;
            rom_frame_q <= rom_frame_d;
            hit_q       <= hit_d;
            hit_dly_q   <= hit_dly_d;
            pix_q       <= pix_d;
            pix_valid_q <= pix_valid_d;
            pal_q       <= pal_d;
        end
    end

    assign rom.rom_addr       = rom_addr_q;
    assign rom.rom_frame      = rom_frame_q;
    assign sprite_pixel       = pix_q;
    assign sprite_pixel_valid = pix_valid_q;
    assign anim_frame         = frame_q;
    assign anim_done          = (state_q == S_DONE);
endmodule

// File: doc/sprite_anim_show.md
# sprite_anim_show

Parametrised sprite renderer with a built-in animation sequencer, for the VGA game layer. Maps the current scan pixel to an address in an external multi-frame index ROM, steps through animation frames on video-frame ticks, resolves the index through a writable palette, and emits a latency-aligned RGB pixel plus a valid flag. The output feeds the same priority mixer as the other show blocks.

## Interface
Parameters:
- SPR_W, 88: sprite width in pixels.
- SPR_H, 84: sprite height in pixels.
- NUM_FRAMES, 13: number of animation frames stored in the ROM.
- FRAME_W, 4: width of frame-number signals; must satisfy 2^FRAME_W ≥ NUM_FRAMES.
- ADDR_W, 13: ROM address width; must satisfy 2^ADDR_W ≥ SPR_W*SPR_H.
- ROM_LAT, 1: ROM read latency in cycles, either 1 or 2.
- HOLD_TICKS, 4: number of frame_tick pulses each animation frame is shown; must be ≥ 1.

Ports:
- clk  in  1  pixel clock.
- rst  in  1  synchronous, active-high reset.
- current_pixel_x, current_pixel_y  in  10 each  scan position.
- sprite_valid  in  1  sprite enable.
- sprite_x, sprite_y  in  10 each  top-left corner of the sprite.
- mirror  in  1  horizontal flip.
- frame_tick  in  1  one-cycle pulse per video frame, asserted during blanking.
- anim_restart  in  1  pulse; samples anim_mode and static_frame, and sets the frame to the start frame.
- anim_mode  in  2  00 static, 01 loop, 10 one-shot, 11 ping-pong.
- static_frame  in  FRAME_W  frame shown in static mode.
- rom_addr  out  ADDR_W  registered pixel address.
- rom_frame  out  FRAME_W  registered frame select.
- rom_data  in  6  bit 5 is opaque, bits 4:0 are the palette index.
- pal_we  in  1  palette write strobe.
- pal_addr  in  5  palette write address.
- pal_data  in  24  palette write data, RGB 8:8:8.
- sprite_pixel  out  24  registered RGB.
- sprite_pixel_valid  out  1  registered; high = opaque sprite pixel.
- anim_frame  out  FRAME_W  current animation frame.
- anim_done  out  1  high when a one-shot sequence has finished.

## Operation
- Hit test: sprite_valid is high, and sprite_x ≤ x ≤ sprite_x+SPR_W-1, and sprite_y ≤ y ≤ sprite_y+SPR_H-1. Compute the bounds at 11 bits so sums never wrap.
- Row index: row = sprite_y+SPR_H-1-y, so ROM row 0 is the bottom line of the sprite.
- Column index: col = x-sprite_x, or SPR_W-1-(x-sprite_x) when mirror=1.
- Address: rom_addr = row*SPR_W+col when the pixel is a hit; otherwise 0.
- Palette: 32×24 register file. A write takes effect on the cycle after pal_we. If a write and a read hit the same entry in the same cycle, the read returns the old value.
- Sequencer states: STATIC, LOOP, ONESHOT, DONE, PP_UP, PP_DOWN.
- The hold counter counts frame_tick pulses. The frame advances on the tick where the counter equals HOLD_TICKS-1, and the counter then clears.
- STATIC: anim_frame = static_frame, captured at restart. frame_tick is ignored.
- LOOP: frame goes 0→NUM_FRAMES-1, then wraps to 0.
- ONESHOT: frame goes 0→NUM_FRAMES-1. On the next advance the state moves to DONE; the frame holds at NUM_FRAMES-1 and anim_done=1.
- PING-PONG, up (PP_UP): counts up. On reaching NUM_FRAMES-1 it switches to PP_DOWN.
- PING-PONG, down (PP_DOWN): counts down. On reaching 0 it switches to PP_UP. End frames are not repeated.
- PING-PONG with NUM_FRAMES=1: the frame stays 0.
- anim_restart: loads the mode, clears the hold counter, sets the frame to 0 (static_frame in static mode), and clears anim_done. It wins over a simultaneous frame_tick.
- Changing anim_mode without anim_restart has no effect.
- anim_frame changes only on a frame_tick or an anim_restart, so a frame never tears mid-screen.

## Timing
- Stage 1 (cycle t+1): rom_addr, rom_frame and the hit flag are registered from the pixel presented at cycle t.
- ROM: rom_data is valid at t+1+ROM_LAT. The hit flag is delayed through matching registers.
- Output (cycle t+2+ROM_LAT): sprite_pixel = palette[idx] and sprite_pixel_valid = hit & opaque.
- Non-hit or transparent pixel: sprite_pixel = 0 and sprite_pixel_valid = 0.
- Total latency L = 2+ROM_LAT; default 3. Throughput is one pixel per clock, with no stalls.
- Reset values: rom_addr=0, rom_frame=0, sprite_pixel=0, sprite_pixel_valid=0, anim_frame=0, anim_done=0. State = STATIC with static_frame=0, hold counter = 0, palette all 0.
- Reset mid-stream flushes the whole pipeline; the valid flag stays 0 for L cycles after rst falls.

## Test plan
- Sprite at (100,50), default parameters, pixel (100,133) → rom_addr=0 one cycle later; pixel (187,50) → rom_addr=83*88+87=7391. With palette[3]=0x185504 and rom_data=0x23, sprite_pixel=0x185504 and valid=1 at t+3.
- Same sprite with mirror=1, pixel (100,133) → rom_addr=87. Pixels (99,y) and (188,y) → valid=0 and pixel=0 at t+3.
- LOOP with HOLD_TICKS=2, NUM_FRAMES=13, 26 ticks → anim_frame steps 0..12, then back to 0. A tick arriving together with anim_restart → frame=0, counter cleared.
- ONESHOT with HOLD_TICKS=1, 13 ticks → frame 12 and anim_done=1; further ticks → no change. A following restart → frame=0 and anim_done=0.
- PING-PONG with NUM_FRAMES=4, HOLD_TICKS=1 → frames 0,1,2,3,2,1,0,1.
- rom_data=0x05 (transparent) → valid=0. Palette write to entry 5 on the same cycle as a read of it → old colour, then the new colour next cycle.
- ROM_LAT=2 build → output latency is 4 cycles.
- rst pulsed mid-line → all outputs 0 and no valid pixels for 4 cycles.
